// File: rtl/rpn_wan_tx_pkg.sv
// Wire format and shared types for the WAN reliable-publish sender/receiver pair.
package rpn_wan_tx_pkg;

  localparam int unsigned AXIS_DATA_WIDTH           = 512;
  localparam int unsigned AXIS_KEEP_WIDTH           = AXIS_DATA_WIDTH / 8;
  localparam int unsigned CLUSTER_ID_WIDTH          = 16;
  localparam int unsigned WAN_SEQUENCE_NUMBER_WIDTH = 32;
  localparam int unsigned RPN_MSG_TYPE_WIDTH        = 8;
  localparam int unsigned KIP_PORT_WIDTH            = 16;
  localparam int unsigned KIP_IP_WIDTH              = 32;
  localparam int unsigned RETRY_CNT_WIDTH           = 8;
  localparam int unsigned TIMER_WIDTH               = 32;

  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_PUB = 8'h10;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_ACK = 8'h11;

  // Publish message: type at bit 0, sender ctid at 8, seq at 24, data at 56.
  localparam int unsigned PUB_WAN_DATA_WIDTH = 256;
  localparam int unsigned PUB_WAN_HDR_WIDTH  =
    RPN_MSG_TYPE_WIDTH + CLUSTER_ID_WIDTH + WAN_SEQUENCE_NUMBER_WIDTH;
  localparam int unsigned PUB_WAN_PAD_WIDTH  =
    AXIS_DATA_WIDTH - PUB_WAN_HDR_WIDTH - PUB_WAN_DATA_WIDTH;

  // ACK message: type at bit 0, ack sender ctid at 8, ack seq at 24.
  localparam int unsigned WAN_ACK_HDR_WIDTH  =
    RPN_MSG_TYPE_WIDTH + CLUSTER_ID_WIDTH + WAN_SEQUENCE_NUMBER_WIDTH;
  localparam int unsigned WAN_ACK_PAD_WIDTH  = AXIS_DATA_WIDTH - WAN_ACK_HDR_WIDTH;

  localparam int unsigned AXIS_KIP_TUSER_WIDTH = 2 * KIP_PORT_WIDTH + KIP_IP_WIDTH;

  typedef struct packed {
    logic [PUB_WAN_PAD_WIDTH-1:0]         pad;
    logic [PUB_WAN_DATA_WIDTH-1:0]        data;
    logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] seq;
    logic [CLUSTER_ID_WIDTH-1:0]          sender_ctid;
    logic [RPN_MSG_TYPE_WIDTH-1:0]        msg_type;
  } pub_wan_msg_t;

  typedef struct packed {
    logic [WAN_ACK_PAD_WIDTH-1:0]         pad;
    logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] seq;
    logic [CLUSTER_ID_WIDTH-1:0]          sender_ctid;
    logic [RPN_MSG_TYPE_WIDTH-1:0]        msg_type;
  } wan_ack_msg_t;

  // KnownIP sideband: {dst port, src port, dest IP}.
  typedef struct packed {
    logic [KIP_PORT_WIDTH-1:0] dst_port;
    logic [KIP_PORT_WIDTH-1:0] src_port;
    logic [KIP_IP_WIDTH-1:0]   dest_ip;
  } kip_tuser_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ_SEQ = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_COMMIT   = 3'd4,
    ST_FAIL     = 3'd5
  } tx_state_e;

endpackage

// File: rtl/rpn_wan_tx_timer.sv
// ACK timeout counter: load clears it, tick advances it, expired flags the last cycle of the window.
module rpn_wan_tx_timer
  import rpn_wan_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o
);

  logic [TIMER_WIDTH-1:0] count_q, count_d;

  // Next count: load has priority over tick.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + TIMER_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rpn_wan_tx.sv
// Stop-and-wait WAN publish sender with per-cluster sequence numbers and ACK-timeout retransmission.
module rpn_wan_tx
  import rpn_wan_tx_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH_P = AXIS_DATA_WIDTH,
  parameter int unsigned AXIS_KEEP_WIDTH_P = AXIS_KEEP_WIDTH,
  parameter int unsigned CLUSTER_ID_W      = CLUSTER_ID_WIDTH,
  parameter int unsigned WAN_SEQ_W         = WAN_SEQUENCE_NUMBER_WIDTH,
  parameter int unsigned BRAM_ADDR_WIDTH   = 12,
  parameter int unsigned TIMEOUT_CYCLES    = 100000,
  parameter int unsigned MAX_RETRIES       = 3
) (
  input  logic                            i_clk,
  input  logic                            i_ap_rst,
  input  logic [CLUSTER_ID_W-1:0]         i_cluster_id,
  input  logic [15:0]                     i_KIP_port_number,

  input  logic                            from_ctrl_tvalid,
  output logic                            from_ctrl_tready,
  input  logic [AXIS_DATA_WIDTH_P-1:0]    from_ctrl_tdata,
  input  logic [CLUSTER_ID_W-1:0]         from_ctrl_tdest,
  input  logic [31:0]                     from_ctrl_tuser,

  output logic                            to_nb_KIP_tvalid,
  input  logic                            to_nb_KIP_tready,
  output logic [AXIS_DATA_WIDTH_P-1:0]    to_nb_KIP_tdata,
  output logic [AXIS_KEEP_WIDTH_P-1:0]    to_nb_KIP_tkeep,
  output logic [AXIS_KIP_TUSER_WIDTH-1:0] to_nb_KIP_tuser,
  output logic                            to_nb_KIP_tlast,

  input  logic                            from_nb_ack_tvalid,
  output logic                            from_nb_ack_tready,
  input  logic [AXIS_DATA_WIDTH_P-1:0]    from_nb_ack_tdata,

  output logic                            to_seq_BRAM_CLK,
  output logic                            to_seq_BRAM_RST,
  output logic                            to_seq_BRAM_EN,
  output logic [3:0]                      to_seq_BRAM_WEN,
  output logic [BRAM_ADDR_WIDTH-1:0]      to_seq_BRAM_ADDR,
  output logic [WAN_SEQ_W-1:0]            to_seq_BRAM_DIN,
  input  logic [WAN_SEQ_W-1:0]            to_seq_BRAM_DOUT,

  output logic                            o_busy,
  output logic                            o_tx_fail,
  output logic [CLUSTER_ID_W-1:0]         o_tx_fail_cluster_id
);

  tx_state_e                     state_q, state_d;
  logic [PUB_WAN_DATA_WIDTH-1:0] data_q, data_d;
  logic [CLUSTER_ID_W-1:0]       dest_q, dest_d;
  logic [31:0]                   ip_q, ip_d;
  logic [WAN_SEQ_W-1:0]          seq_q, seq_d;
  logic [RETRY_CNT_WIDTH-1:0]    retries_q, retries_d;
  logic [CLUSTER_ID_W-1:0]       fail_id_q, fail_id_d;

  logic          timer_load, timer_tick, timer_expired;
  logic          ctrl_fire, ack_match;
  wan_ack_msg_t  ack_msg;
  pub_wan_msg_t  pub_msg;
  kip_tuser_t    kip_user;
  logic [CLUSTER_ID_W-1:0] addr_ctid;
  logic          unused_bits;

  assign ctrl_fire = from_ctrl_tvalid & from_ctrl_tready;
  assign ack_msg   = from_nb_ack_tdata;
  assign ack_match = from_nb_ack_tvalid
                   & (ack_msg.msg_type == RPN_MSG_TYPE_WAN_ACK)
                   & (ack_msg.sender_ctid == dest_q)
                   & (ack_msg.seq == seq_q);

  rpn_wan_tx_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (i_clk),
    .rst_i     (i_ap_rst),
    .load_i    (timer_load),
    .tick_i    (timer_tick),
    .expired_o (timer_expired)
  );

  // State and message context registers.
  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      dest_q    <= '0;
      ip_q      <= '0;
      seq_q     <= '0;
      retries_q <= '0;
      fail_id_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
      ip_q      <= ip_d;
      seq_q     <= seq_d;
      retries_q <= retries_d;
      fail_id_q <= fail_id_d;
    end
  end

  // Next-state logic; a matching ACK always beats a coincident timeout.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    dest_d     = dest_q;
    ip_d       = ip_q;
    seq_d      = seq_q;
    retries_d  = retries_q;
    fail_id_d  = fail_id_q;
    timer_load = 1'b0;
    timer_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_fire) begin
          data_d  = from_ctrl_tdata[PUB_WAN_DATA_WIDTH-1:0];
          dest_d  = from_ctrl_tdest;
          ip_d    = from_ctrl_tuser;
          state_d = ST_READ_SEQ;
        end
      end
      ST_READ_SEQ: begin
        seq_d     = to_seq_BRAM_DOUT + WAN_SEQ_W'(1);
        retries_d = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if ((retries_q != '0) && ack_match) begin
          state_d = ST_COMMIT;
        end else if (to_nb_KIP_tready) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_tick = 1'b1;
        if (ack_match) begin
          state_d = ST_COMMIT;
        end else if (timer_expired) begin
          if (retries_q < RETRY_CNT_WIDTH'(MAX_RETRIES)) begin
            retries_d = retries_q + RETRY_CNT_WIDTH'(1);
            state_d   = ST_SEND;
          end else begin
            fail_id_d = dest_q;
            state_d   = ST_FAIL;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outbound publish beat, built only from registered context so it holds under backpressure.
  always_comb begin
    pub_msg             = '0;
    pub_msg.data        = data_q;
    pub_msg.seq         = seq_q;
    pub_msg.sender_ctid = i_cluster_id;
    pub_msg.msg_type    = RPN_MSG_TYPE_WAN_PUB;
    kip_user.dst_port   = i_KIP_port_number;
    kip_user.src_port   = i_KIP_port_number;
    kip_user.dest_ip    = ip_q;
  end

  assign to_nb_KIP_tvalid = (state_q == ST_SEND);
  assign to_nb_KIP_tdata  = pub_msg;
  assign to_nb_KIP_tkeep  = '1;
  assign to_nb_KIP_tuser  = kip_user;
  assign to_nb_KIP_tlast  = 1'b1;

  assign from_ctrl_tready   = (state_q == ST_IDLE) & ~i_ap_rst;
  assign from_nb_ack_tready = ~i_ap_rst;

  // The read is issued on the accept cycle so DOUT is ready in READ_SEQ.
  assign addr_ctid        = (state_q == ST_IDLE) ? from_ctrl_tdest : dest_q;
  assign to_seq_BRAM_CLK  = i_clk;
  assign to_seq_BRAM_RST  = i_ap_rst;
  assign to_seq_BRAM_EN   = ctrl_fire | (state_q == ST_COMMIT);
  assign to_seq_BRAM_WEN  = (state_q == ST_COMMIT) ? 4'hF : 4'h0;
  assign to_seq_BRAM_ADDR = {addr_ctid[BRAM_ADDR_WIDTH-3:0], 2'b00};
  assign to_seq_BRAM_DIN  = seq_q;

  assign o_busy               = (state_q != ST_IDLE);
  assign o_tx_fail            = (state_q == ST_FAIL);
  assign o_tx_fail_cluster_id = fail_id_q;

  assign unused_bits = ^{from_ctrl_tdata[AXIS_DATA_WIDTH_P-1:PUB_WAN_DATA_WIDTH],
                         ack_msg.pad, addr_ctid[CLUSTER_ID_W-1:BRAM_ADDR_WIDTH-2]};

endmodule

// File: tb/tb_rpn_wan_tx.sv
// Directed bench for rpn_wan_tx with a behavioural sequence BRAM.
module tb_rpn_wan_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  cluster_id;
  logic [15:0]  port_num;
  logic         ctrl_tvalid, ctrl_tready;
  logic [511:0] ctrl_tdata;
  logic [15:0]  ctrl_tdest;
  logic [31:0]  ctrl_tuser;
  logic         kip_tvalid, kip_tready, kip_tlast;
  logic [511:0] kip_tdata;
  logic [63:0]  kip_tkeep;
  logic [63:0]  kip_tuser;
  logic         ack_tvalid, ack_tready;
  logic [511:0] ack_tdata;
  logic         bram_clk, bram_rst, bram_en;
  logic [3:0]   bram_wen;
  logic [11:0]  bram_addr;
  logic [31:0]  bram_din, bram_dout;
  logic         busy, tx_fail;
  logic [15:0]  fail_id;

  int checks = 0;
  int failures = 0;

  logic [31:0]  mem [1024];
  logic         tb_init;
  int           bram_writes = 0;
  int           cyc = 0;
  int           fail_high = 0;
  logic [511:0] beat_data [$];
  logic [63:0]  beat_user [$];
  int           beat_cyc [$];

  always #5 clk = ~clk;

  rpn_wan_tx #(
    .TIMEOUT_CYCLES (16),
    .MAX_RETRIES    (2)
  ) dut (
    .i_clk                (clk),
    .i_ap_rst             (rst),
    .i_cluster_id         (cluster_id),
    .i_KIP_port_number    (port_num),
    .from_ctrl_tvalid     (ctrl_tvalid),
    .from_ctrl_tready     (ctrl_tready),
    .from_ctrl_tdata      (ctrl_tdata),
    .from_ctrl_tdest      (ctrl_tdest),
    .from_ctrl_tuser      (ctrl_tuser),
    .to_nb_KIP_tvalid     (kip_tvalid),
    .to_nb_KIP_tready     (kip_tready),
    .to_nb_KIP_tdata      (kip_tdata),
    .to_nb_KIP_tkeep      (kip_tkeep),
    .to_nb_KIP_tuser      (kip_tuser),
    .to_nb_KIP_tlast      (kip_tlast),
    .from_nb_ack_tvalid   (ack_tvalid),
    .from_nb_ack_tready   (ack_tready),
    .from_nb_ack_tdata    (ack_tdata),
    .to_seq_BRAM_CLK      (bram_clk),
    .to_seq_BRAM_RST      (bram_rst),
    .to_seq_BRAM_EN       (bram_en),
    .to_seq_BRAM_WEN      (bram_wen),
    .to_seq_BRAM_ADDR     (bram_addr),
    .to_seq_BRAM_DIN      (bram_din),
    .to_seq_BRAM_DOUT     (bram_dout),
    .o_busy               (busy),
    .o_tx_fail            (tx_fail),
    .o_tx_fail_cluster_id (fail_id)
  );

  // Sequence BRAM model plus beat / write / fail-pulse recorders.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5] <= 32'd7;
      mem[3] <= 32'hFFFF_FFFF;
    end else if (bram_en) begin
      bram_dout <= mem[bram_addr[11:2]];
      if (bram_wen == 4'hF) begin
        mem[bram_addr[11:2]] <= bram_din;
        bram_writes <= bram_writes + 1;
      end
    end
    if (kip_tvalid && kip_tready) begin
      beat_data.push_back(kip_tdata);
      beat_user.push_back(kip_tuser);
      beat_cyc.push_back(cyc);
    end
    if (tx_fail) fail_high <= fail_high + 1;
  end

  function automatic logic [511:0] pub_word(input logic [31:0] seq, input logic [255:0] d);
    logic [511:0] w;
    w = '0;
    w[7:0]    = 8'h10;
    w[23:8]   = 16'h0042;
    w[55:24]  = seq;
    w[311:56] = d;
    return w;
  endfunction

  function automatic logic [511:0] ack_word(input logic [7:0] t, input logic [15:0] c,
                                            input logic [31:0] s);
    logic [511:0] w;
    w = '0;
    w[7:0]   = t;
    w[23:8]  = c;
    w[55:24] = s;
    return w;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic publish(input logic [15:0] dst, input logic [31:0] ip, input logic [255:0] d);
    int n;
    n = 0;
    while (ctrl_tready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ctrl_ready_before_publish", 512'(ctrl_tready), 512'(1));
    ctrl_tvalid = 1'b1;
    ctrl_tdata  = {{8{32'hFFFF_FFFF}}, d};
    ctrl_tdest  = dst;
    ctrl_tuser  = ip;
    tick();
    ctrl_tvalid = 1'b0;
    ctrl_tdata  = '0;
  endtask

  task automatic send_ack(input logic [7:0] t, input logic [15:0] c, input logic [31:0] s);
    ack_tvalid = 1'b1;
    ack_tdata  = ack_word(t, c, s);
    tick();
    ack_tvalid = 1'b0;
    ack_tdata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] d1, d2, d3, d4, d5, d6;
    int nb, wb, n;
    d1 = {8{32'hDEAD_BEEF}};
    d2 = {8{32'h0123_4567}};
    d3 = {8{32'hA5A5_5A5A}};
    d4 = {8{32'h1111_2222}};
    d5 = {8{32'hCAFE_F00D}};
    d6 = {8{32'h7777_0001}};

    rst = 1'b1; tb_init = 1'b1;
    cluster_id = 16'h0042; port_num = 16'h1234;
    ctrl_tvalid = 1'b0; ctrl_tdata = '0; ctrl_tdest = '0; ctrl_tuser = '0;
    kip_tready = 1'b1; ack_tvalid = 1'b0; ack_tdata = '0;
    tick(); tick(); tick();

    // Reset state
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_kip_tvalid", 512'(kip_tvalid), 512'(0));
    check("rst_tx_fail", 512'(tx_fail), 512'(0));
    check("rst_ctrl_tready", 512'(ctrl_tready), 512'(0));
    check("rst_ack_tready", 512'(ack_tready), 512'(0));
    check("rst_fail_id", 512'(fail_id), 512'(0));
    check("rst_bram_en", 512'(bram_en), 512'(0));
    check("rst_bram_wen", 512'(bram_wen), 512'(0));
    tb_init = 1'b0; rst = 1'b0;
    tick();
    check("ack_tready_after_rst", 512'(ack_tready), 512'(1));

    // Basic publish: BRAM[5]=7 -> seq 8, commit on ACK(5,8)
    publish(16'd5, 32'h0A00_0001, d1);
    check("t1_busy", 512'(busy), 512'(1));
    check("t1_tvalid_readseq", 512'(kip_tvalid), 512'(0));
    tick();
    check("t1_tvalid_latency", 512'(kip_tvalid), 512'(1));
    check("t1_tdata", kip_tdata, pub_word(32'd8, d1));
    check("t1_tuser", 512'(kip_tuser), 512'({16'h1234, 16'h1234, 32'h0A00_0001}));
    check("t1_tkeep", 512'(kip_tkeep), 512'({64{1'b1}}));
    check("t1_tlast", 512'(kip_tlast), 512'(1));
    tick();
    check("t1_tvalid_waitack", 512'(kip_tvalid), 512'(0));
    check("t1_beats", 512'(beat_data.size()), 512'(1));
    send_ack(8'h11, 16'd5, 32'd7);
    check("t1_stale_seq_dropped", 512'(busy), 512'(1));
    send_ack(8'h11, 16'd6, 32'd8);
    check("t1_wrong_ctid_dropped", 512'(bram_wen), 512'(0));
    send_ack(8'h10, 16'd5, 32'd8);
    check("t1_wrong_type_dropped", 512'(ctrl_tready), 512'(0));
    send_ack(8'h11, 16'd5, 32'd8);
    check("t1_commit_wen", 512'(bram_wen), 512'(4'hF));
    check("t1_commit_en", 512'(bram_en), 512'(1));
    check("t1_commit_addr", 512'(bram_addr), 512'(12'd20));
    check("t1_commit_din", 512'(bram_din), 512'(32'd8));
    tick();
    check("t1_mem5", 512'(mem[5]), 512'(32'd8));
    check("t1_idle", 512'(busy), 512'(0));
    check("t1_writes", 512'(bram_writes), 512'(1));

    // Sequence wrap: BRAM[3]=FFFFFFFF -> seq 0
    publish(16'd3, 32'h0A00_0002, d2);
    tick();
    check("t2_tdata_wrap", kip_tdata, pub_word(32'd0, d2));
    tick();
    send_ack(8'h11, 16'd3, 32'd0);
    check("t2_commit_din", 512'(bram_din), 512'(32'd0));
    tick();
    check("t2_mem3", 512'(mem[3]), 512'(32'd0));

    // No ACK: three identical beats, SEND + 16 wait cycles apart, then a fail pulse
    nb = beat_data.size();
    wb = bram_writes;
    publish(16'd5, 32'h0A00_0003, d3);
    n = 0;
    while (tx_fail !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("t3_fail_seen", 512'(tx_fail), 512'(1));
    check("t3_fail_id", 512'(fail_id), 512'(16'd5));
    check("t3_beat_count", 512'(beat_data.size() - nb), 512'(3));
    if (beat_data.size() >= nb + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t3_beat_data", beat_data[nb + i], pub_word(32'd9, d3));
        check("t3_beat_user", 512'(beat_user[nb + i]), 512'({16'h1234, 16'h1234, 32'h0A00_0003}));
      end
      check("t3_gap1", 512'(beat_cyc[nb + 1] - beat_cyc[nb]), 512'(17));
      check("t3_gap2", 512'(beat_cyc[nb + 2] - beat_cyc[nb + 1]), 512'(17));
    end
    tick();
    check("t3_fail_pulse_width", 512'(fail_high), 512'(1));
    check("t3_fail_low", 512'(tx_fail), 512'(0));
    check("t3_idle", 512'(busy), 512'(0));
    check("t3_fail_id_holds", 512'(fail_id), 512'(16'd5));
    check("t3_mem5_unchanged", 512'(mem[5]), 512'(32'd8));
    check("t3_no_write", 512'(bram_writes), 512'(wb));

    // ACK arriving on the timeout cycle wins, no retransmit
    publish(16'd5, 32'h0A00_0004, d4);
    tick();
    check("t4_tdata", kip_tdata, pub_word(32'd9, d4));
    tick();
    nb = beat_data.size();
    repeat (15) tick();
    check("t4_still_waiting", 512'(busy), 512'(1));
    check("t4_no_tvalid", 512'(kip_tvalid), 512'(0));
    send_ack(8'h11, 16'd5, 32'd9);
    check("t4_commit_wen", 512'(bram_wen), 512'(4'hF));
    check("t4_commit_din", 512'(bram_din), 512'(32'd9));
    tick();
    check("t4_no_retransmit", 512'(beat_data.size()), 512'(nb));
    check("t4_mem5", 512'(mem[5]), 512'(32'd9));

    // Backpressure: tvalid and data held, ctrl_tready stays low
    kip_tready = 1'b0;
    publish(16'd7, 32'h0A00_0007, d5);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t5_tvalid_held", 512'(kip_tvalid), 512'(1));
      check("t5_tdata_stable", kip_tdata, pub_word(32'd1, d5));
      check("t5_ctrl_blocked", 512'(ctrl_tready), 512'(0));
      tick();
    end
    check("t5_tuser_stable", 512'(kip_tuser), 512'({16'h1234, 16'h1234, 32'h0A00_0007}));
    nb = beat_data.size();
    kip_tready = 1'b1;
    tick();
    check("t5_one_beat", 512'(beat_data.size() - nb), 512'(1));
    send_ack(8'h11, 16'd7, 32'd1);
    check("t5_ctrl_blocked_commit", 512'(ctrl_tready), 512'(0));
    tick();
    check("t5_mem7", 512'(mem[7]), 512'(32'd1));
    check("t5_ctrl_ready_again", 512'(ctrl_tready), 512'(1));

    // Reset during WAIT_ACK: no write, next message resends DOUT+1
    publish(16'd9, 32'h0A00_0009, d6);
    tick();
    tick();
    wb = bram_writes;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 512'(busy), 512'(0));
    check("t6_rst_tvalid", 512'(kip_tvalid), 512'(0));
    check("t6_rst_bram_en", 512'(bram_en), 512'(0));
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_write", 512'(bram_writes), 512'(wb));
    check("t6_mem9", 512'(mem[9]), 512'(32'd0));
    publish(16'd9, 32'h0A00_0009, d6);
    tick();
    check("t6_resend_seq", kip_tdata, pub_word(32'd1, d6));
    tick();
    send_ack(8'h11, 16'd9, 32'd1);
    tick();
    check("t6_mem9_commit", 512'(mem[9]), 512'(32'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
